// File: rtl/led_pwm_driver.sv
// ---------------------------------------------------------------------------
// led_pwm_driver
//
// Downstream stage of the 8-bit LED PIO. The PIO out_port value arrives on
// led_in as a per-LED on/off mask; this block applies a global PWM brightness
// gate and an optional blink gate, then registers the result onto the LED
// pins. A small zero-wait-state Avalon-MM slave holds the control registers.
//
// Register map (write when chipselect && !write_n, unused read bits are 0):
//   0  CTRL          bit0 EN, bit1 BLINK_EN              (reset 0)
//   1  DUTY          [PWM_BITS-1:0]                      (reset 0x80)
//   2  PRESCALE      [PRESCALE_W-1:0]                    (reset 0)
//   3  BLINK_PERIOD  [PRESCALE_W-1:0]                    (reset 0)
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   led_in      LED mask from the PIO out_port
//   address     Avalon register select
//   chipselect  Avalon chip select
//   write_n     Avalon write strobe, active-low
//   writedata   Avalon write data
//   readdata    Avalon read data, combinational from address
//   led_out     registered LED pin drive (1 cycle after led_in)
// ---------------------------------------------------------------------------
module led_pwm_driver #(
  parameter int NUM_LEDS   = 8,
  parameter int PWM_BITS   = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_LEDS-1:0] led_in,
  input  logic [1:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic [NUM_LEDS-1:0] led_out
);

  localparam logic [PWM_BITS-1:0] DUTY_RESET = PWM_BITS'(128);

  // -------------------------------------------------------------------------
  // Register file
  // -------------------------------------------------------------------------
  logic                  en_reg,           en_next;
  logic                  blink_en_reg,     blink_en_next;
  logic [PWM_BITS-1:0]   duty_reg,         duty_next;
  logic [PRESCALE_W-1:0] prescale_reg,     prescale_next;
  logic [PRESCALE_W-1:0] blink_period_reg, blink_period_next;

  // Counter state
  logic [PRESCALE_W-1:0] pre_cnt_reg,      pre_cnt_next;
  logic [PWM_BITS-1:0]   pwm_cnt_reg,      pwm_cnt_next;
  logic [PRESCALE_W-1:0] blink_cnt_reg,    blink_cnt_next;
  logic                  blink_phase_reg,  blink_phase_next;

  logic [NUM_LEDS-1:0]   led_out_reg,      led_out_next;

  // One write strobe per register address.
  logic [3:0] wr_sel;
  logic       wr_any;

  assign wr_any = chipselect && !write_n;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_wr_sel
      assign wr_sel[gi] = wr_any && (address == 2'(gi));
    end
  endgenerate

  // Upper write-data bits have no register behind them.
  logic wdata_unused;
  assign wdata_unused = ^writedata[31:PRESCALE_W];

  // -------------------------------------------------------------------------
  // Register writes
  // -------------------------------------------------------------------------
  always_comb begin
    en_next           = en_reg;
    blink_en_next     = blink_en_reg;
    duty_next         = duty_reg;
    prescale_next     = prescale_reg;
    blink_period_next = blink_period_reg;

    if (wr_sel[0]) begin
      en_next       = writedata[0];
      blink_en_next = writedata[1];
    end
    if (wr_sel[1]) begin
      duty_next = writedata[PWM_BITS-1:0];
    end
    if (wr_sel[2]) begin
      prescale_next = writedata[PRESCALE_W-1:0];
    end
    if (wr_sel[3]) begin
      blink_period_next = writedata[PRESCALE_W-1:0];
    end
  end

  // -------------------------------------------------------------------------
  // Prescaler, PWM counter, blink counter
  // -------------------------------------------------------------------------
  logic tick;
  logic period_end;

  assign tick       = en_reg && (pre_cnt_reg == prescale_reg);
  assign period_end = tick && (pwm_cnt_reg == '1);

  always_comb begin
    pre_cnt_next     = pre_cnt_reg;
    pwm_cnt_next     = pwm_cnt_reg;
    blink_cnt_next   = blink_cnt_reg;
    blink_phase_next = blink_phase_reg;

    if (!en_reg) begin
      // Disabled: everything parks at its start point so that enabling
      // always begins a fresh PWM period with the blink phase on.
      pre_cnt_next     = '0;
      pwm_cnt_next     = '0;
      blink_cnt_next   = '0;
      blink_phase_next = 1'b1;
    end else begin
      pre_cnt_next = tick ? '0 : pre_cnt_reg + PRESCALE_W'(1);

      if (tick) begin
        pwm_cnt_next = pwm_cnt_reg + PWM_BITS'(1);
      end

      if (period_end) begin
        if (blink_cnt_reg == blink_period_reg) begin
          blink_phase_next = ~blink_phase_reg;
          blink_cnt_next   = '0;
        end else begin
          blink_cnt_next = blink_cnt_reg + PRESCALE_W'(1);
        end
      end
    end

    // Register-write side effects win over any increment on the same edge.
    if (wr_sel[2]) begin
      pre_cnt_next = '0;
    end
    if (wr_sel[3]) begin
      blink_cnt_next   = '0;
      blink_phase_next = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Output gate
  // -------------------------------------------------------------------------
  logic pwm_on;
  logic gate;

  assign pwm_on = (pwm_cnt_reg < duty_reg);
  assign gate   = !en_reg || (pwm_on && (!blink_en_reg || blink_phase_reg));

  generate
    for (gi = 0; gi < NUM_LEDS; gi++) begin : g_led_gate
      assign led_out_next[gi] = led_in[gi] & gate;
    end
  endgenerate

  assign led_out = led_out_reg;

  // -------------------------------------------------------------------------
  // Read mux: zero-extended, no side effects
  // -------------------------------------------------------------------------
  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata[1:0]            = {blink_en_reg, en_reg};
      2'd1: readdata[PWM_BITS-1:0]   = duty_reg;
      2'd2: readdata[PRESCALE_W-1:0] = prescale_reg;
      2'd3: readdata[PRESCALE_W-1:0] = blink_period_reg;
      default: readdata = '0;
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_reg           <= 1'b0;
      blink_en_reg     <= 1'b0;
      duty_reg         <= DUTY_RESET;
      prescale_reg     <= '0;
      blink_period_reg <= '0;
      pre_cnt_reg      <= '0;
      pwm_cnt_reg      <= '0;
      blink_cnt_reg    <= '0;
      blink_phase_reg  <= 1'b1;
      led_out_reg      <= '0;
    end else begin
      en_reg           <= en_next;
      blink_en_reg     <= blink_en_next;
      duty_reg         <= duty_next;
      prescale_reg     <= prescale_next;
      blink_period_reg <= blink_period_next;
      pre_cnt_reg      <= pre_cnt_next;
      pwm_cnt_reg      <= pwm_cnt_next;
      blink_cnt_reg    <= blink_cnt_next;
      blink_phase_reg  <= blink_phase_next;
      led_out_reg      <= led_out_next;
    end
  end

endmodule

// File: tb/tb_led_pwm_driver.sv
// ---------------------------------------------------------------------------
// tb_led_pwm_driver
//
// Self-checking bench for led_pwm_driver. A behavioural model tracks the
// number of prescaler ticks and completed PWM periods as plain integers and
// derives the expected LED drive from them each cycle. Directed scenarios
// follow the block's intended use; a randomized phase mixes register writes,
// readbacks and changing led_in.
// ---------------------------------------------------------------------------
module tb_led_pwm_driver;

  localparam int N   = 8;
  localparam int PB  = 8;
  localparam int PW  = 16;
  localparam int PWM_PERIOD = 1 << PB;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  led_in = '0;
  logic [1:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [N-1:0]  led_out;

  always #5 clk = ~clk;

  led_pwm_driver #(.NUM_LEDS(N), .PWM_BITS(PB), .PRESCALE_W(PW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .led_in    (led_in),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .led_out   (led_out)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit m_en, m_blink;
  int m_duty, m_prescale, m_bp;
  int m_pre;      // cycles elapsed in the current prescale interval
  int m_ticks;    // prescaler ticks since enable
  int m_periods;  // completed PWM periods since the blink reference point

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_blink = 0; m_duty = 128; m_prescale = 0; m_bp = 0;
    m_pre = 0; m_ticks = 0; m_periods = 0;
  endtask

  function automatic bit model_gate();
    bit pwm_on, phase;
    if (!m_en) return 1'b1;
    pwm_on = (m_ticks % PWM_PERIOD) < m_duty;
    // Phase flips after every (BLINK_PERIOD+1) completed PWM periods.
    phase  = ((m_periods / (m_bp + 1)) % 2) == 0;
    return pwm_on && (!m_blink || phase);
  endfunction

  // One clock: predict led_out from pre-edge state, advance the model,
  // then check after the edge.
  task automatic cycle();
    logic [N-1:0] exp_out;
    bit tick;
    exp_out = model_gate() ? led_in : '0;
    if (!m_en) begin
      m_pre = 0; m_ticks = 0; m_periods = 0;
    end else begin
      tick  = (m_pre == m_prescale);
      m_pre = tick ? 0 : m_pre + 1;
      if (tick) begin
        if ((m_ticks % PWM_PERIOD) == PWM_PERIOD - 1) m_periods++;
        m_ticks++;
      end
    end
    if (chipselect && !write_n) begin
      case (address)
        2'd0: begin m_en = writedata[0]; m_blink = writedata[1]; end
        2'd1: m_duty = int'(writedata[PB-1:0]);
        2'd2: begin m_prescale = int'(writedata[PW-1:0]); m_pre = 0; end
        default: begin m_bp = int'(writedata[PW-1:0]); m_periods = 0; end
      endcase
    end
    @(posedge clk);
    #1;
    check_val("led_out", 32'(led_out), 32'(exp_out));
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    $display("WR addr=%0d data=%08h", a, d);
    cycle();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic reg_read(input logic [1:0] a, input logic [31:0] exp, input string tag);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
    check_val(tag, readdata, exp);
    $display("RD addr=%0d data=%08h", a, readdata);
    chipselect = 1'b0;
  endtask

  task automatic readback_all(input string tag);
    reg_read(2'd0, {30'b0, m_blink, m_en}, {tag, "_ctrl"});
    reg_read(2'd1, 32'(m_duty), {tag, "_duty"});
    reg_read(2'd2, 32'(m_prescale), {tag, "_prescale"});
    reg_read(2'd3, 32'(m_bp), {tag, "_blink_period"});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Counts cycles with all LEDs lit, with led_in held at all-ones.
  task automatic run_count(input int n, output int on_cnt);
    on_cnt = 0;
    for (int i = 0; i < n; i++) begin
      cycle();
      if (led_out == '1) on_cnt++;
    end
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      led_in = N'($urandom);
      cycle();
    end
  endtask

  initial begin
    int on_cnt;
    logic [31:0] d;
    logic [1:0]  a;

    // Scenario 1: reset behaviour and pass-through
    model_reset();
    led_in = 8'hA5;
    repeat (3) begin
      @(posedge clk); #1;
      check_val("reset_led_out", 32'(led_out), 32'h0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    cycle();
    check_val("passthru_a5", 32'(led_out), 32'hA5);
    readback_all("rst_vals");
    led_in = 8'h3C;
    cycle();

    // Scenario 2: 25% duty, no prescale
    led_in = '1;
    reg_write(2'd2, 32'd0);
    reg_write(2'd1, 32'h40);
    reg_write(2'd0, 32'h1);
    run(4);
    run_count(PWM_PERIOD, on_cnt);
    check_val("duty40_on_cycles", 32'(on_cnt), 32'd64);

    // Scenario 3: duty extremes
    reg_write(2'd1, 32'h00);
    run(2);
    run_count(PWM_PERIOD, on_cnt);
    check_val("duty00_on_cycles", 32'(on_cnt), 32'd0);
    reg_write(2'd1, 32'hFF);
    run(2);
    run_count(PWM_PERIOD, on_cnt);
    check_val("dutyff_on_cycles", 32'(on_cnt), 32'd255);

    // Scenario 4: prescale 3, half duty, then restart prescaler mid-count
    reg_write(2'd1, 32'h80);
    reg_write(2'd2, 32'd3);
    run(4);
    run_count(4 * PWM_PERIOD, on_cnt);
    check_val("pre3_on_cycles", 32'(on_cnt), 32'd512);
    run(2);
    reg_write(2'd2, 32'd3);
    run(30);
    reg_write(2'd2, 32'd1);
    run(40);
    readback_all("pre_write");

    // Scenario 5: blink every 2 PWM periods at full duty
    reg_write(2'd2, 32'd0);
    reg_write(2'd1, 32'hFF);
    reg_write(2'd3, 32'd1);
    reg_write(2'd0, 32'h3);
    run(8);
    run_count(4 * PWM_PERIOD, on_cnt);
    check_val("blink_on_cycles", 32'(on_cnt), 32'd510);
    run(300);

    // Scenario 6: asynchronous reset mid-blink
    #3;
    reset_n = 1'b0;
    #1;
    check_val("async_rst_led_out", 32'(led_out), 32'h0);
    model_reset();
    readback_all("async_rst");
    @(posedge clk); #1;
    check_val("in_rst_led_out", 32'(led_out), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    led_in = 8'hA5;
    cycle();
    check_val("post_rst_passthru", 32'(led_out), 32'hA5);
    readback_all("post_rst");

    // Randomized phase
    for (int t = 0; t < 120; t++) begin
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      if (a == 2'd0) d[0] = ($urandom_range(0, 3) != 0);
      if (a == 2'd2) d[PW-1:0] = PW'($urandom_range(0, 3));
      if (a == 2'd3) d[PW-1:0] = PW'($urandom_range(0, 2));
      led_in = N'($urandom);
      reg_write(a, d);
      run_random($urandom_range(1, 400));
      if ($urandom_range(0, 7) == 0) readback_all("rand");
    end
    readback_all("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
